// File: rtl/baby_vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : baby_vga_pkg
// Description : Shared constants, colour type and VGA PMOD packing for baby_vga.
// Revision    : 1.0 - initial release
// ============================================================================
package baby_vga_pkg;

   localparam int ADDR_W      = 5;
   localparam int COLOUR_BITS = 6;

   typedef logic [COLOUR_BITS-1:0] colour_t;

   localparam logic [ADDR_W-1:0] ADDR_FG = 5'd16;
   localparam logic [ADDR_W-1:0] ADDR_BG = 5'd17;

   localparam colour_t FG_RESET = 6'h3F;
   localparam colour_t BG_RESET = 6'h00;

   // Colour bit positions inside colour_t {R1,R0,G1,G0,B1,B0}
   localparam int COL_R1 = 5;
   localparam int COL_R0 = 4;
   localparam int COL_G1 = 3;
   localparam int COL_G0 = 2;
   localparam int COL_B1 = 1;
   localparam int COL_B0 = 0;

   // TinyTapeout VGA PMOD bit positions
   localparam int VGA_HSYNC = 7;
   localparam int VGA_B0    = 6;
   localparam int VGA_G0    = 5;
   localparam int VGA_R0    = 4;
   localparam int VGA_VSYNC = 3;
   localparam int VGA_B1    = 2;
   localparam int VGA_G1    = 1;
   localparam int VGA_R1    = 0;

   function automatic logic [7:0] pack_vga(input logic hsync, input logic vsync,
                                           input colour_t colour);
      logic [7:0] w_byte;
      w_byte            = '0;
      w_byte[VGA_HSYNC] = hsync;
      w_byte[VGA_VSYNC] = vsync;
      w_byte[VGA_R1]    = colour[COL_R1];
      w_byte[VGA_R0]    = colour[COL_R0];
      w_byte[VGA_G1]    = colour[COL_G1];
      w_byte[VGA_G0]    = colour[COL_G0];
      w_byte[VGA_B1]    = colour[COL_B1];
      w_byte[VGA_B0]    = colour[COL_B0];
      return w_byte;
   endfunction

endpackage
`default_nettype wire

// File: rtl/baby_vga_framebuffer.sv
`default_nettype none
// ============================================================================
// Module      : baby_vga_framebuffer
// Description : NUM_ROWS x NUM_COLS 1-bit flop framebuffer, one write port,
//               independent row-read ports for pixel lookup and CPU readback.
// Revision    : 1.0 - initial release
// ============================================================================
module baby_vga_framebuffer
   import baby_vga_pkg::*;
#(
   parameter int NUM_ROWS = 16,
   parameter int NUM_COLS = 32,
   localparam int ROW_W   = $clog2(NUM_ROWS)
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [ROW_W-1:0]    wr_row,
   input  logic [NUM_COLS-1:0] wr_data,
   input  logic [ROW_W-1:0]    pix_row,
   output logic [NUM_COLS-1:0] pix_word,
   input  logic [ROW_W-1:0]    rd_row,
   output logic [NUM_COLS-1:0] rd_word
);

   logic [NUM_COLS-1:0] r_mem [NUM_ROWS];

   // Storage is intentionally unreset; software initialises it before display
   generate
      for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
         always_ff @(posedge clk) begin
            if (wr_en && (wr_row == ROW_W'(g)))
               r_mem[g] <= wr_data;
         end
      end
   endgenerate

   assign pix_word = r_mem[pix_row];
   assign rd_word  = r_mem[rd_row];

endmodule
`default_nettype wire

// File: rtl/baby_vga_pixel_out.sv
`default_nettype none
// ============================================================================
// Module      : baby_vga_pixel_out
// Description : Framebuffer pixel lookup, frame-synchronous colour registers
//               and registered VGA PMOD output for the baby_vga pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module baby_vga_pixel_out
   import baby_vga_pkg::*;
#(
   parameter int NUM_ROWS = 16,
   parameter int NUM_COLS = 32,
   parameter int COLOUR_W = COLOUR_BITS
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [$clog2(NUM_COLS)-1:0] x_pos,
   input  logic [$clog2(NUM_ROWS)-1:0] y_pos,
   input  logic                        blank,
   input  logic                        hsync_in,
   input  logic                        vsync_in,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [NUM_COLS-1:0]         wr_data,
   input  logic [ADDR_W-1:0]           rd_addr,
   output logic [NUM_COLS-1:0]         rd_data,
   output logic [7:0]                  vga_out,
   output logic                        frame_tick
);

   localparam int ROW_W = $clog2(NUM_ROWS);
   localparam logic [ADDR_W-1:0] C_ROW_LIMIT = ADDR_W'(NUM_ROWS);

   logic [COLOUR_W-1:0] r_fg_shadow, r_bg_shadow, r_fg_active, r_bg_active;
   logic                r_vsync_prev;
   logic [7:0]          r_vga_out;
   logic                r_frame_tick;

   logic [NUM_COLS-1:0] w_pix_word, w_rd_word;
   logic                w_row_wr, w_fg_wr, w_bg_wr, w_boundary, w_pix;
   logic [COLOUR_W-1:0] w_fg_next, w_bg_next, w_colour;

   assign w_row_wr = wr_en && (wr_addr < C_ROW_LIMIT);
   assign w_fg_wr  = wr_en && (wr_addr == ADDR_FG);
   assign w_bg_wr  = wr_en && (wr_addr == ADDR_BG);

   baby_vga_framebuffer #(
      .NUM_ROWS (NUM_ROWS),
      .NUM_COLS (NUM_COLS)
   ) u_fb (
      .clk      (clk),
      .wr_en    (w_row_wr),
      .wr_row   (wr_addr[ROW_W-1:0]),
      .wr_data  (wr_data),
      .pix_row  (y_pos),
      .pix_word (w_pix_word),
      .rd_row   (rd_addr[ROW_W-1:0]),
      .rd_word  (w_rd_word)
   );

   // A colour write landing on the boundary cycle must reach the active copy too
   assign w_fg_next  = w_fg_wr ? wr_data[COLOUR_W-1:0] : r_fg_shadow;
   assign w_bg_next  = w_bg_wr ? wr_data[COLOUR_W-1:0] : r_bg_shadow;
   assign w_boundary = r_vsync_prev & ~vsync_in;
   assign w_pix      = w_pix_word[x_pos];
   assign w_colour   = blank ? '0 : (w_pix ? r_fg_active : r_bg_active);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fg_shadow  <= FG_RESET;
         r_bg_shadow  <= BG_RESET;
         r_fg_active  <= FG_RESET;
         r_bg_active  <= BG_RESET;
         r_vsync_prev <= 1'b1;
         r_frame_tick <= 1'b0;
         r_vga_out    <= pack_vga(1'b1, 1'b1, BG_RESET);
      end else begin
         r_fg_shadow  <= w_fg_next;
         r_bg_shadow  <= w_bg_next;
         if (w_boundary) begin
            r_fg_active <= w_fg_next;
            r_bg_active <= w_bg_next;
         end
         r_vsync_prev <= vsync_in;
         r_frame_tick <= w_boundary;
         r_vga_out    <= pack_vga(hsync_in, vsync_in, w_colour);
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_addr < C_ROW_LIMIT)
         rd_data = w_rd_word;
      else if (rd_addr == ADDR_FG)
         rd_data[COLOUR_W-1:0] = r_fg_shadow;
      else if (rd_addr == ADDR_BG)
         rd_data[COLOUR_W-1:0] = r_bg_shadow;
   end

   assign vga_out    = r_vga_out;
   assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_baby_vga_pixel_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_baby_vga_pixel_out
// Description : Directed and randomized self-checking bench for baby_vga_pixel_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_baby_vga_pixel_out;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [4:0]  x_pos = '0;
   logic [3:0]  y_pos = '0;
   logic        blank = 1'b0;
   logic        hsync_in = 1'b1;
   logic        vsync_in = 1'b1;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [4:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic [7:0]  vga_out;
   logic        frame_tick;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   baby_vga_pixel_out dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .blank      (blank),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .vga_out    (vga_out),
      .frame_tick (frame_tick)
   );

   // Reference model state
   logic [31:0] m_fb [16];
   logic [5:0]  m_fg_sh, m_bg_sh, m_fg_act, m_bg_act;
   logic        m_vprev;
   logic [7:0]  m_vga;
   logic        m_tick;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // PMOD byte {hsync,B0,G0,R0,vsync,B1,G1,R1} from colour {R1,R0,G1,G0,B1,B0}
   function automatic logic [7:0] vga_byte(input logic h, input logic v, input logic [5:0] c);
      logic r1, r0, g1, g0, b1, b0;
      {r1, r0, g1, g0, b1, b0} = c;
      return {h, b0, g0, r0, v, b1, g1, r1};
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a < 5'd16) return m_fb[a[3:0]];
      if (a == 5'd16) return {26'b0, m_fg_sh};
      if (a == 5'd17) return {26'b0, m_bg_sh};
      return 32'h0;
   endfunction

   task automatic model_reset();
      m_fg_sh  = 6'h3F;
      m_bg_sh  = 6'h00;
      m_fg_act = 6'h3F;
      m_bg_act = 6'h00;
      m_vprev  = 1'b1;
      m_vga    = 8'h88;
      m_tick   = 1'b0;
   endtask

   // One clock: model evaluates the inputs seen at the edge, then DUT outputs are compared
   task automatic step();
      logic [5:0] col;
      logic       pix, boundary;
      pix      = m_fb[y_pos][x_pos];
      col      = blank ? 6'h00 : (pix ? m_fg_act : m_bg_act);
      boundary = m_vprev && !vsync_in;
      @(posedge clk);
      #1;
      m_vga  = vga_byte(hsync_in, vsync_in, col);
      m_tick = boundary;
      if (wr_en) begin
         if (wr_addr < 5'd16)       m_fb[wr_addr[3:0]] = wr_data;
         else if (wr_addr == 5'd16) m_fg_sh = wr_data[5:0];
         else if (wr_addr == 5'd17) m_bg_sh = wr_data[5:0];
      end
      if (boundary) begin
         m_fg_act = m_fg_sh;
         m_bg_act = m_bg_sh;
      end
      m_vprev = vsync_in;
      check_val("vga_out", {24'b0, vga_out}, {24'b0, m_vga});
      check_val("frame_tick", {31'b0, frame_tick}, {31'b0, m_tick});
      wr_en = 1'b0;
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      step();
   endtask

   task automatic check_rd(input logic [4:0] a);
      rd_addr = a;
      #1;
      check_val($sformatf("rd_data@%0d", a), rd_data, m_read(a));
   endtask

   task automatic set_pix(input logic [4:0] x, input logic [3:0] y, input logic b,
                          input logic h, input logic v);
      x_pos = x; y_pos = y; blank = b; hsync_in = h; vsync_in = v;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_fb[i] = '0;
      model_reset();

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      check_val("rst_vga", {24'b0, vga_out}, 32'h88);
      check_val("rst_tick", {31'b0, frame_tick}, 32'h0);
      check_rd(5'd16);
      check_rd(5'd17);
      check_val("rst_fg_const", rd_data, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Row readback with distinct patterns
      for (int i = 0; i < 16; i++) write(5'(i), 32'h1357_9BDF * (i + 1) ^ 32'(i));
      for (int i = 0; i < 16; i++) check_rd(5'(i));
      check_rd(5'd20);
      check_val("rd_unmapped", rd_data, 32'h0);

      // Pixel on with reset colours
      write(5'd3, 32'h0000_0001);
      set_pix(5'd0, 4'd3, 1'b0, 1'b1, 1'b1);
      step();
      check_val("t2_fg", {24'b0, vga_out}, 32'hFF);
      set_pix(5'd1, 4'd3, 1'b0, 1'b1, 1'b1);
      step();
      check_val("t2_bg", {24'b0, vga_out}, 32'h88);

      // Deferred colour
      set_pix(5'd0, 4'd3, 1'b0, 1'b1, 1'b1);
      write(5'd16, 32'h30);
      write(5'd17, 32'h03);
      step();
      check_val("t3_hold", {24'b0, vga_out}, 32'hFF);
      check_rd(5'd16);
      check_rd(5'd17);
      vsync_in = 1'b0;
      step();
      check_val("t3_tick", {31'b0, frame_tick}, 32'h1);
      step();
      check_val("t3_tick_once", {31'b0, frame_tick}, 32'h0);
      set_pix(5'd0, 4'd3, 1'b0, 1'b1, 1'b1);
      step();
      check_val("t3_fg", {24'b0, vga_out}, 32'h99);
      set_pix(5'd1, 4'd3, 1'b0, 1'b1, 1'b1);
      step();
      check_val("t3_bg", {24'b0, vga_out}, 32'hCC);

      // Blank and syncs
      set_pix(5'd0, 4'd3, 1'b1, 1'b0, 1'b1);
      step();
      check_val("t4_hsync", {24'b0, vga_out}, 32'h08);
      set_pix(5'd0, 4'd3, 1'b1, 1'b1, 1'b0);
      step();
      check_val("t4_vsync", {24'b0, vga_out}, 32'h80);

      // Colour write on the boundary cycle, row write in the lookup cycle
      set_pix(5'd0, 4'd3, 1'b0, 1'b1, 1'b1);
      step();
      vsync_in = 1'b0;
      write(5'd16, 32'h0C);
      set_pix(5'd0, 4'd3, 1'b0, 1'b1, 1'b1);
      step();
      check_val("t5_fg_boundary", {24'b0, vga_out}, 32'hAA);
      set_pix(5'd1, 4'd3, 1'b0, 1'b1, 1'b1);
      write(5'd3, 32'h0000_0003);
      check_val("t5_old_pix", {24'b0, vga_out}, 32'hCC);
      step();
      check_val("t5_new_pix", {24'b0, vga_out}, 32'hAA);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         x_pos    = 5'($urandom);
         y_pos    = 4'($urandom);
         blank    = ($urandom_range(0, 3) == 0);
         hsync_in = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) vsync_in = ~vsync_in;
         wr_en    = ($urandom_range(0, 3) == 0);
         wr_addr  = ($urandom_range(0, 2) == 0) ? 5'(16 + $urandom_range(0, 1)) : 5'($urandom);
         wr_data  = $urandom;
         step();
         check_rd(5'($urandom));
      end

      // Asynchronous reset mid-cycle
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_val("mid_rst_vga", {24'b0, vga_out}, 32'h88);
      check_val("mid_rst_tick", {31'b0, frame_tick}, 32'h0);
      check_rd(5'd16);
      check_rd(5'd17);
      @(posedge clk);
      #1;
      check_val("mid_rst_hold", {24'b0, vga_out}, 32'h88);
      rst_n = 1'b1;

      for (int n = 0; n < 60; n++) begin
         x_pos    = 5'($urandom);
         y_pos    = 4'($urandom);
         blank    = ($urandom_range(0, 3) == 0);
         hsync_in = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 7) == 0) vsync_in = ~vsync_in;
         wr_en    = ($urandom_range(0, 2) == 0);
         wr_addr  = 5'(16 + $urandom_range(0, 1));
         wr_data  = $urandom;
         step();
         check_rd(5'($urandom_range(14, 19)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
